adc_capture_responder: RTL

Receive-side responder to the transmit controller's ADC trigger handshake. Accepts `itxADCTriggerLine` requests, returns `orxADCTriggerAck`, waits a programmed delay, then writes a fixed-length record of parallel ADC samples into sample memory. Successive triggers append records at consecutive addresses. The host disarms the block to clear it.

---
 rtl/adc_capture_responder_if.sv | 25 ++
 rtl/adc_capture_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adc_capture_responder_if.sv
// Trigger handshake and sample-memory write bus shared between the
// transmit-side trigger source, the ADC front end and the capture responder.
interface adc_capture_responder_if #(
   parameter int NUM_CH      = 8,
   parameter int SAMPLE_BITS = 12,
   parameter int ADDR_BITS   = 15
);
   logic                          itxADCTriggerLine;
   logic                          orxADCTriggerAck;
   logic [NUM_CH*SAMPLE_BITS-1:0] irxADCData;
   logic                          irxADCDataValid;
   logic [ADDR_BITS-1:0]          oSampleWriteAddr;
   logic [NUM_CH*SAMPLE_BITS-1:0] oSampleWriteData;
   logic                          oSampleWriteEn;

   modport slave (
      input  itxADCTriggerLine, irxADCData, irxADCDataValid,
      output orxADCTriggerAck, oSampleWriteAddr, oSampleWriteData, oSampleWriteEn
   );

   modport master (
      output itxADCTriggerLine, irxADCData, irxADCDataValid,
      input  orxADCTriggerAck, oSampleWriteAddr, oSampleWriteData, oSampleWriteEn
   );
endinterface

// File: rtl/adc_capture_responder.sv
// Answers ADC trigger requests with a 4-phase ack, waits the programmed delay,
// then appends a fixed-length record of ADC words to sample memory.
module adc_capture_responder #(
   parameter int NUM_CH      = 8,
   parameter int SAMPLE_BITS = 12,
   parameter int ADDR_BITS   = 15,
   parameter int DELAY_BITS  = 16
) (
   input  logic                  rxCLK,
   input  logic                  rxRESETn,
   adc_capture_responder_if.slave bus,
   input  logic [7:0]            irxControlComms,
   input  logic [DELAY_BITS-1:0] irxCaptureDelay,
   input  logic [ADDR_BITS-1:0]  irxRecordLength,
   output logic [15:0]           orxTriggerCount,
   output logic                  orxBufferFull,
   output logic                  orxBusy
);
   localparam int DW = NUM_CH * SAMPLE_BITS;
   localparam logic [ADDR_BITS-1:0] PTR_MAX = '1;

   typedef enum logic [1:0] {WAIT_TRIG, DELAY, CAPTURE} state_t;

   state_t                state_q, state_d;
   logic                  ack_q, ack_d;
   logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
   logic [ADDR_BITS-1:0]  rem_q, rem_d;
   logic [DELAY_BITS-1:0] dly_q, dly_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  full_q, full_d;
   logic                  we_q, we_d;
   logic [ADDR_BITS-1:0]  waddr_q, waddr_d;
   logic [DW-1:0]         wdata_q, wdata_d;

   logic arm;
   logic accept;

   assign arm    = (irxControlComms == 8'h01);
   assign accept = (state_q == WAIT_TRIG) && !ack_q && arm && bus.itxADCTriggerLine;

   always_ff @(posedge rxCLK or negedge rxRESETn) begin
      if (!rxRESETn) begin
         state_q <= WAIT_TRIG;
         ack_q   <= 1'b0;
         ptr_q   <= '0;
         rem_q   <= '0;
         dly_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      if (!arm) begin
         state_d = WAIT_TRIG;
         ack_d   = 1'b0;
         ptr_d   = '0;
         cnt_d   = '0;
         full_d  = 1'b0;
      end else begin
         if (ack_q && !bus.itxADCTriggerLine)
            ack_d = 1'b0;
         unique case (state_q)
            WAIT_TRIG: begin
               if (accept) begin
                  ack_d = 1'b1;
                  if (cnt_q != 16'hFFFF)
                     cnt_d = cnt_q + 16'd1;
                  // A full buffer still completes the handshake so the transmitter never stalls.
                  if (!full_q) begin
                     dly_d   = irxCaptureDelay;
                     rem_d   = irxRecordLength;
                     state_d = DELAY;
                  end
               end
            end
            DELAY: begin
               if (dly_q == '0)
                  state_d = CAPTURE;
               else
                  dly_d = dly_q - DELAY_BITS'(1);
            end
            CAPTURE: begin
               if (rem_q == '0) begin
                  state_d = WAIT_TRIG;
               end else if (bus.irxADCDataValid) begin
                  we_d    = 1'b1;
                  waddr_d = ptr_q;
                  wdata_d = bus.irxADCData;
                  rem_d   = rem_q - ADDR_BITS'(1);
                  // Last address: flag full, hold the pointer and end the record.
                  if (ptr_q == PTR_MAX) begin
                     full_d  = 1'b1;
                     state_d = WAIT_TRIG;
                  end else begin
                     ptr_d = ptr_q + ADDR_BITS'(1);
                     if (rem_q == ADDR_BITS'(1))
                        state_d = WAIT_TRIG;
                  end
               end
            end
            default: state_d = WAIT_TRIG;
         endcase
      end
   end

   assign bus.orxADCTriggerAck = ack_q;
   assign bus.oSampleWriteEn   = we_q;
   assign bus.oSampleWriteAddr = waddr_q;
   assign bus.oSampleWriteData = wdata_q;
   assign orxTriggerCount      = cnt_q;
   assign orxBufferFull        = full_q;
   assign orxBusy              = (state_q != WAIT_TRIG);
endmodule
